// File: rtl/axi_defines.sv
// AXI channel payload types, response codes and LSU bridge state encoding
// shared by axi_inf and axi_lsu_master.
package axi_defines;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef struct packed {
      logic                  valid;
      logic [AXI_ADDR_W-1:0] addr;
      logic [2:0]            prot;
   } aw_t;

   typedef struct packed {
      logic                  valid;
      logic [AXI_ADDR_W-1:0] addr;
      logic [2:0]            prot;
   } ar_t;

   typedef struct packed {
      logic                    valid;
      logic [AXI_DATA_W-1:0]   data;
      logic [AXI_DATA_W/8-1:0] strb;
      logic                    last;
   } w_t;

   typedef struct packed {
      logic                  valid;
      logic [AXI_DATA_W-1:0] data;
      logic [1:0]            resp;
      logic                  last;
   } r_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] resp;
   } b_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      DONE
   } lsu_state_e;

endpackage

// File: rtl/axi_inf.sv
// Single-clock AXI bundle: channel structs carry their own valid, readies
// travel as separate signals.
interface axi_inf;
   import axi_defines::*;

   aw_t  aw;
   logic awready;
   w_t   w;
   logic wready;
   b_t   b;
   logic bready;
   ar_t  ar;
   logic arready;
   r_t   r;
   logic rready;

   modport master (
      output aw, w, ar, bready, rready,
      input  awready, wready, b, arready, r
   );

   modport slave (
      input  aw, w, ar, bready, rready,
      output awready, wready, b, arready, r
   );

endinterface

// File: rtl/axi_lsu_master.sv
// Core load/store port to single-beat AXI master, one transaction in flight.
// Optional misalignment trap: define AXI_LSU_ALIGN_CHECK_EN.
module axi_lsu_master
   import axi_defines::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   axi_inf.master              m_axi
);

   lsu_state_e state, state_n;

   logic aw_valid, w_valid, ar_valid, bready, rready, aw_done, w_done;
   logic aw_valid_n, w_valid_n, ar_valid_n, bready_n, rready_n, aw_done_n, w_done_n;
   logic req_ready_n, rsp_valid_n, rsp_err_n;
   logic [DATA_W-1:0] rsp_rdata_n;
   logic accept, misaligned;

   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] be_q;
   logic [ADDR_W-1:0]   axi_addr;

`ifdef AXI_LSU_ALIGN_CHECK_EN
   assign misaligned = (req_addr[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_n     = state;
      aw_valid_n  = aw_valid;
      w_valid_n   = w_valid;
      ar_valid_n  = ar_valid;
      bready_n    = bready;
      rready_n    = rready;
      aw_done_n   = aw_done;
      w_done_n    = w_done;
      rsp_valid_n = 1'b0;
      rsp_rdata_n = rsp_rdata;
      rsp_err_n   = rsp_err;
      accept      = 1'b0;

      case (state)
         IDLE: begin
            if (req_ready && req_valid) begin
               accept = 1'b1;
               if (misaligned) begin
                  state_n     = DONE;
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b1;
                  rsp_rdata_n = '0;
               end else if (req_we) begin
                  state_n    = WR_REQ;
                  aw_valid_n = 1'b1;
                  w_valid_n  = 1'b1;
                  aw_done_n  = 1'b0;
                  w_done_n   = 1'b0;
               end else begin
                  state_n    = RD_REQ;
                  ar_valid_n = 1'b1;
               end
            end
         end
         WR_REQ: begin
            // AW and W complete independently; either may finish first.
            if (aw_valid && m_axi.awready) begin
               aw_valid_n = 1'b0;
               aw_done_n  = 1'b1;
            end
            if (w_valid && m_axi.wready) begin
               w_valid_n = 1'b0;
               w_done_n  = 1'b1;
            end
            if (aw_done_n && w_done_n) begin
               state_n  = WR_RESP;
               bready_n = 1'b1;
            end
         end
         WR_RESP: begin
            if (m_axi.b.valid) begin
               bready_n    = 1'b0;
               rsp_err_n   = (m_axi.b.resp != AXI_RESP_OKAY);
               rsp_rdata_n = '0;
               rsp_valid_n = 1'b1;
               state_n     = DONE;
            end
         end
         RD_REQ: begin
            if (m_axi.arready) begin
               ar_valid_n = 1'b0;
               rready_n   = 1'b1;
               state_n    = RD_RESP;
            end
         end
         RD_RESP: begin
            if (m_axi.r.valid) begin
               rready_n    = 1'b0;
               rsp_rdata_n = m_axi.r.data;
               rsp_err_n   = (m_axi.r.resp != AXI_RESP_OKAY);
               rsp_valid_n = 1'b1;
               state_n     = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      req_ready_n = (state_n == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         aw_valid  <= 1'b0;
         w_valid   <= 1'b0;
         ar_valid  <= 1'b0;
         bready    <= 1'b0;
         rready    <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         aw_valid  <= aw_valid_n;
         w_valid   <= w_valid_n;
         ar_valid  <= ar_valid_n;
         bready    <= bready_n;
         rready    <= rready_n;
         aw_done   <= aw_done_n;
         w_done    <= w_done_n;
         req_ready <= req_ready_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         rsp_err   <= rsp_err_n;
      end
   end

   // Request payload is only meaningful while a valid is up, so it is not reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
   end

   assign axi_addr = addr_q & ~ADDR_W'(3);

   assign m_axi.aw = '{valid: aw_valid, addr: axi_addr, prot: 3'b000};
   assign m_axi.ar = '{valid: ar_valid, addr: axi_addr, prot: 3'b000};
   assign m_axi.w  = '{valid: w_valid, data: wdata_q, strb: be_q, last: 1'b1};
   assign m_axi.bready = bready;
   assign m_axi.rready = rready;

endmodule
